// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: sequential double-dabble binary-to-BCD converter with valid/ready handshakes
module bcd_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               x,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [4*DIGITS-1:0]            BCD,
  output logic [$clog2(DIGITS+1)-1:0]    ndigits,
  output logic                           busy
);
  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int NW = $clog2(DIGITS + 1);
  function automatic logic [127:0] pow10(input int n);
    logic [127:0] p;
    p = 128'd1;
    for (int i = 0; i < n; i++) p = p * 128'd10;
    return p;
  endfunction
  if (pow10(DIGITS) <= (128'd1 << WIDTH) - 128'd1) begin : g_bad
    $error("bcd_seq_ctrl: DIGITS too small for WIDTH");
  end
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_d;
  logic [SW-1:0] sr, adj, sr_d;
  logic [CW-1:0] cnt;
  logic [NW-1:0] nd_d;
  logic last;
  assign last      = cnt == CW'(WIDTH - 1);
  assign in_ready  = state == IDLE && !rst;
  assign out_valid = state == DONE;
  assign busy      = state == SHIFT;
  always_comb begin
    adj = sr;
    for (int i = 0; i < DIGITS; i++)
      adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] >= 4'd5 ? sr[WIDTH+4*i +: 4] + 4'd3 : sr[WIDTH+4*i +: 4];
    sr_d = adj << 1;
    nd_d = NW'(1);
    for (int i = 1; i < DIGITS; i++)
      if (sr_d[WIDTH+4*i +: 4] != 4'd0) nd_d = NW'(i + 1);
  end
  always_comb begin
    state_d = state;
    state_d = state == IDLE  ? (in_valid  ? SHIFT : IDLE)
            : state == SHIFT ? (last      ? DONE  : SHIFT)
            : state == DONE  ? (out_ready ? IDLE  : DONE)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      BCD     <= '0;
      ndigits <= NW'(1);
    end else begin
      state <= state_d;
      if (state == IDLE && in_valid) begin
        sr  <= {{(4*DIGITS){1'b0}}, x};
        cnt <= '0;
      end else if (state == SHIFT) begin
        sr  <= sr_d;
        cnt <= cnt + CW'(1);
      end
      // Results are captured from the final shift, so BCD/ndigits hold steady until the next conversion ends.
      if (state == SHIFT && last) begin
        BCD     <= sr_d[SW-1:WIDTH];
        ndigits <= nd_d;
      end
    end
  end
endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// tb_bcd_seq_ctrl: table, corner-case and random/exhaustive checks of bcd_seq_ctrl against a decimal model
module tb_bcd_seq_ctrl;
  logic clk = 0;
  logic rst, in_valid, out_ready;
  logic [7:0] x;
  logic in_ready, out_valid, busy;
  logic [11:0] BCD;
  logic [1:0] ndigits;
  int total = 0, bad = 0;

  bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .BCD(BCD), .ndigits(ndigits), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  x;
    logic [11:0] bcd;
    logic [1:0]  nd;
  } vec_t;
  vec_t tv[8];

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int ref_nd(input int v);
    return v >= 100 ? 3 : v >= 10 ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input logic [7:0] v, output int lat, output logic bok);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    x = v;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    x = 8'($urandom);
    lat = 1;
    bok = 1;
    while (!out_valid && lat < 30) begin
      bok &= busy;
      @(negedge clk);
      x = 8'($urandom);
      lat++;
    end
    bok &= !busy;
  endtask

  task automatic hs();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    chk("hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat, cyc, last_acc, hold;
    logic bok;
    logic [7:0] v;
    logic [7:0] q[$];
    tv[0] = '{8'd255, 12'h255, 2'd3};
    tv[1] = '{8'd0,   12'h000, 2'd1};
    tv[2] = '{8'd9,   12'h009, 2'd1};
    tv[3] = '{8'd100, 12'h100, 2'd3};
    tv[4] = '{8'd42,  12'h042, 2'd2};
    tv[5] = '{8'd99,  12'h099, 2'd2};
    tv[6] = '{8'd10,  12'h010, 2'd2};
    tv[7] = '{8'd128, 12'h128, 2'd3};
    rst = 1;
    in_valid = 0;
    out_ready = 0;
    x = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(BCD), 32'd0);
    chk("rst_nd", 32'(ndigits), 32'd1);
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run(tv[i].x, lat, bok);
      chk("tbl_bcd", 32'(BCD), 32'(tv[i].bcd));
      chk("tbl_nd", 32'(ndigits), 32'(tv[i].nd));
      chk("tbl_latency", 32'(lat), 32'd9);
      chk("tbl_busy", 32'(bok), 32'd1);
      hs();
    end

    run(8'd42, lat, bok);
    for (int i = 0; i < 5; i++) begin
      chk("hold_bcd", 32'(BCD), 32'h042);
      chk("hold_nd", 32'(ndigits), 32'd2);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    hs();

    x = 8'd200;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(BCD), 32'd0);
    chk("abort_nd", 32'(ndigits), 32'd1);
    rst = 0;
    @(negedge clk);
    run(8'd17, lat, bok);
    chk("after_abort_bcd", 32'(BCD), 32'h017);
    chk("after_abort_nd", 32'(ndigits), 32'd2);
    chk("after_abort_latency", 32'(lat), 32'd9);
    hs();

    out_ready = 1;
    last_acc = -1;
    cyc = 0;
    while ((cyc < 60 || q.size() > 0) && cyc < 120) begin
      if (out_valid) begin
        if (q.size() == 0) chk("stream_extra", 32'd1, 32'd0);
        else begin
          v = q.pop_front();
          chk("stream_bcd", 32'(BCD), 32'(ref_bcd(int'(v))));
        end
      end
      in_valid = cyc < 60;
      x = 8'($urandom);
      if (in_ready && in_valid) begin
        if (last_acc >= 0) chk("stream_gap", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
        q.push_back(x);
      end
      @(negedge clk);
      cyc++;
    end
    chk("stream_drain", 32'(q.size()), 32'd0);
    in_valid = 0;
    out_ready = 0;
    @(negedge clk);

    for (int i = 0; i < 256; i++) begin
      run(8'(i), lat, bok);
      chk("sweep_bcd", 32'(BCD), 32'(ref_bcd(i)));
      chk("sweep_nd", 32'(ndigits), 32'(ref_nd(i)));
      chk("sweep_latency", 32'(lat), 32'd9);
      hold = $urandom_range(0, 2);
      repeat (hold) @(negedge clk);
      hs();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
